// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based ITCM request issue with a circular
// buffer of {pc, inst} entries feeding the execution stage.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     req_en_p,
    input  logic [31:0]              pc_p,
    input  logic [31:0]              inst_i,
    input  logic                     flush_x,
    output logic                     deq_v,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_inst,
    input  logic                     deq_rdy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   LIM  = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          infl_q;
    logic [31:0]   pc_q;

    logic [CW:0]   used;
    logic          full;
    logic          push;
    logic          wr;
    logic          pop;

    // Credit counts the in-flight fetch so a response always has a slot.
    assign used     = {1'b0, cnt} + {{CW{1'b0}}, infl_q};
    assign req_en_p = reset & ~flush_x & (used < LIM);

    assign full  = (cnt == FULL);
    assign push  = infl_q & ~flush_x;
    assign wr    = push & ~full;
    assign deq_v = (cnt != '0);
    assign pop   = deq_v & deq_rdy & ~flush_x;

    assign count    = cnt;
    assign deq_pc   = pc_mem[head];
    assign deq_inst = inst_mem[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            infl_q <= 1'b0;
            pc_q   <= '0;
            ovf    <= 1'b0;
        end else begin
            infl_q <= req_en_p & ~flush_x;
            if (req_en_p) pc_q <= pc_p;
            if (flush_x) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (wr)  tail <= tail + 1'b1;
                if (pop) head <= head + 1'b1;
                cnt <= cnt + CW'(wr) - CW'(pop);
            end
            if (push && full) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[tail]   <= pc_q;
            inst_mem[tail] <= inst_i;
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-004 req_en_p  output  1  fetch credit; upstream PC stage SHALL present and advance its PC only in cycles where this is 1.
REQ-005 pc_p  input  32  PC presented to ITCM this cycle; meaningful only when req_en_p=1.
REQ-006 inst_i  input  32  ITCM read data, valid exactly one cycle after the cycle with req_en_p=1.
REQ-007 flush_x  input  1  redirect from execution stage (taken branch/jump); kills all queued and in-flight fetches.
REQ-008 deq_v  output  1  head entry valid to execution stage.
REQ-009 deq_pc  output  32  PC of head entry.
REQ-010 deq_inst  output  32  instruction of head entry.
REQ-011 deq_rdy  input  1  execution stage accepts head this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 ovf  output  1  sticky overflow error flag, for verification only.

Function
REQ-014 Storage: DEPTH entries of {pc[31:0], inst[31:0]}, circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-015 In-flight tracking: register infl_q <= req_en_p & ~flush_x; register pc_q <= pc_p when req_en_p=1.
REQ-016 Credit: req_en_p = (count + infl_q < DEPTH) & ~flush_x; no combinational path from deq_rdy or inst_i to req_en_p.
REQ-017 Push: in any cycle with infl_q=1 and flush_x=0, write {pc_q, inst_i} at tail, tail+1.
REQ-018 Pop: when deq_v=1, deq_rdy=1 and flush_x=0, head+1.
REQ-019 Simultaneous push and pop: both occur; count unchanged.
REQ-020 deq_v = (count != 0); deq_pc/deq_inst driven from head entry combinationally from registered state; no bypass from inst_i.
REQ-021 Latency: request accepted in cycle N -> entry visible at deq_v in cycle N+2 (queue empty case).
REQ-022 Order: entries dequeued strictly in request order.
REQ-023 Flush: when flush_x=1, next cycle count=0, head=tail=0, infl_q=0; response arriving in the flush cycle is discarded; req_en_p=0 during the flush cycle.
REQ-024 Flush has priority over push and pop in the same cycle.
REQ-025 Full: credit rule guarantees push never occurs with count=DEPTH; if it does, entry SHALL be dropped and ovf set to 1 until reset.
REQ-026 deq_rdy while deq_v=0 SHALL have no effect.
REQ-027 deq_pc/deq_inst content undefined when deq_v=0; must hold stable while deq_v=1 and deq_rdy=0.

Reset
REQ-028 While reset=0: count=0, head=tail=0, infl_q=0, ovf=0, deq_v=0, req_en_p=0.
REQ-029 Reset assertion mid-operation discards all entries and in-flight fetch immediately (asynchronous).
REQ-030 First cycle after reset release: req_en_p=1 (count=0, infl_q=0), unless flush_x=1.

Verification
REQ-031 Stream: deq_rdy=1, pc_p=0x0,0x4,0x8..., inst_i=pc^0xA5A5A5A5 -> deq sequence pc 0x0,0x4,0x8 with matching inst, first deq_v two cycles after reset release, one entry per cycle thereafter.
REQ-032 Backpressure: deq_rdy=0, DEPTH=4 -> exactly 4 entries queued, req_en_p=0 from the cycle count+infl_q reaches 4, count=4, ovf=0; release deq_rdy -> entries 0x0..0xC in order, req_en_p returns 1 the cycle after first pop.
REQ-033 Flush with full queue and fetch in flight: flush_x=1 one cycle -> next cycle count=0, deq_v=0, in-flight inst discarded; new PC 0x100 fetched after flush appears as next deq_pc=0x100.
REQ-034 Simultaneous push/pop at count=2 -> count stays 2, order preserved across pointer wrap (run >= 3*DEPTH entries).
REQ-035 Reset asserted with count=3 -> count=0, deq_v=0, req_en_p=0 without waiting for clk edge; normal stream resumes after release.
REQ-036 Forced overflow (inject infl_q push at count=DEPTH via force) -> ovf=1, sticky until reset, queue contents unchanged.
